// File: rtl/mining_job_controller.sv
// mining_job_controller: assembles a 112-byte job from two USB data packets, walks the nonce through the hash core and holds the result.
// Define MINER_HASH_COUNT_EN to add a saturating hash_count output.
module mining_job_controller #(
    parameter int unsigned NONCE_STEP = 1,
    parameter int unsigned P1_BYTES   = 63,
    parameter int unsigned P2_BYTES   = 49
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx_pkt_start,
    input  logic [3:0]   rx_pid,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         rx_pkt_end,
    input  logic         rx_crc_ok,
    input  logic         hc_ready,
    output logic         hc_start,
    output logic [639:0] hc_header,
    input  logic         hc_done,
    input  logic [255:0] hc_hash,
    output logic         busy,
    output logic         result_valid,
    output logic [1:0]   result_status,
    output logic [31:0]  result_nonce,
    input  logic         result_ack
`ifdef MINER_HASH_COUNT_EN
    ,
    output logic [31:0]  hash_count
`endif
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_RX1, S_WAIT2, S_RX2, S_ISSUE, S_WAITH, S_RES} state_t;
    localparam logic [3:0]  PID_DATA0  = 4'h3;
    localparam logic [3:0]  PID_DATA1  = 4'hB;
    localparam logic [7:0]  CMD_HASH   = 8'h01;
    localparam logic [31:0] LAST_NONCE = 32'hFFFF_FFFF - 32'(NONCE_STEP - 1);

    state_t       state_q;
    logic [895:0] buf_q;
    logic [6:0]   cnt_q, cnt_d;
    logic         cmd_q, hc_start_q, busy_q, res_valid_q;
    logic [1:0]   res_status_q, code_d;
    logic [31:0]  res_nonce_q, nonce, nonce_d;
    logic         byte_in, data0_start, mining, mcmd, hit, less, fin_d;
`ifdef MINER_HASH_COUNT_EN
    logic [31:0]  hash_count_q;
    assign hash_count = hash_count_q;
`endif

    assign nonce       = buf_q[287:256];
    assign byte_in     = rx_valid && !rx_pkt_end;
    assign data0_start = rx_pkt_start && rx_pid == PID_DATA0;
    assign mining      = state_q == S_ISSUE || state_q == S_WAITH;
    // a command byte arriving while mining preempts any hash result in the same cycle
    assign mcmd        = mining && cmd_q && byte_in;
    assign hit         = state_q == S_WAITH && hc_done && !mcmd;
    assign less        = hc_hash < buf_q[255:0];
    assign cnt_d       = cnt_q == 7'd127 ? cnt_q : cnt_q + 7'd1;
    assign nonce_d     = nonce + 32'(NONCE_STEP);
    assign code_d      = hit ? (less ? 2'b01 : 2'b10) : 2'b11;

    assign hc_start      = hc_start_q;
    assign hc_header     = buf_q[895:256];
    assign busy          = busy_q;
    assign result_valid  = res_valid_q;
    assign result_status = res_status_q;
    assign result_nonce  = res_nonce_q;

    always_comb begin
        fin_d = 1'b0;
        case (state_q)
            S_CMD:            fin_d = (byte_in && rx_data != CMD_HASH) || rx_pkt_end;
            S_RX1:            fin_d = rx_pkt_end && !(cnt_q == 7'(P1_BYTES) && rx_crc_ok);
            S_WAIT2:          fin_d = data0_start;
            S_RX2:            fin_d = rx_pkt_end && !(cnt_q == 7'(P2_BYTES) && rx_crc_ok);
            S_ISSUE, S_WAITH: fin_d = (mcmd && rx_data != CMD_HASH) || (hit && (less || nonce >= LAST_NONCE));
            default:          fin_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            buf_q        <= '0;
            cnt_q        <= '0;
            cmd_q        <= 1'b0;
            hc_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_status_q <= '0;
            res_nonce_q  <= '0;
`ifdef MINER_HASH_COUNT_EN
            hash_count_q <= '0;
`endif
        end else begin
            hc_start_q <= 1'b0;
            cmd_q      <= mining && (data0_start || (cmd_q && !byte_in && !rx_pkt_end));
`ifdef MINER_HASH_COUNT_EN
            if (hit && hash_count_q != 32'hFFFF_FFFF) hash_count_q <= hash_count_q + 32'd1;
`endif
            if (fin_d) begin
                state_q      <= S_RES;
                busy_q       <= 1'b0;
                res_valid_q  <= 1'b1;
                res_status_q <= code_d;
                res_nonce_q  <= nonce;
            end else begin
                case (state_q)
                    S_IDLE: if (data0_start) state_q <= S_CMD;
                    S_CMD: if (byte_in) begin
                        state_q <= S_RX1;
                        cnt_q   <= '0;
                    end
                    S_RX1, S_RX2: if (rx_pkt_end) begin
                        state_q <= state_q == S_RX1 ? S_WAIT2 : S_ISSUE;
                        busy_q  <= state_q == S_RX2;
`ifdef MINER_HASH_COUNT_EN
                        if (state_q == S_RX2) hash_count_q <= '0;
`endif
                    end else if (byte_in) begin
                        buf_q <= {buf_q[887:0], rx_data};
                        cnt_q <= cnt_d;
                    end
                    S_WAIT2: if (rx_pkt_start && rx_pid == PID_DATA1) begin
                        state_q <= S_RX2;
                        cnt_q   <= '0;
                    end
                    S_ISSUE, S_WAITH: if (mcmd) begin
                        state_q <= S_RX1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (state_q == S_ISSUE && hc_ready) begin
                        hc_start_q <= 1'b1;
                        state_q    <= S_WAITH;
                    end else if (hit) begin
                        buf_q[287:256] <= nonce_d;
                        state_q        <= S_ISSUE;
                    end
                    S_RES: if (data0_start || result_ack) begin
                        state_q      <= data0_start ? S_CMD : S_IDLE;
                        res_valid_q  <= 1'b0;
                        res_status_q <= '0;
                        res_nonce_q  <= '0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule
